// File: rtl/adc128s_pkg.sv
// adc128s shared constants: channel table reset values and frame field positions.
// ADC128S_RAMP_EN (in adc128s.sv) enables the per-frame channel ramp.
package adc128s_pkg;

    localparam int NUM_CH   = 8;
    localparam int DATA_W   = 12;
    localparam int ADDR_MSB = 13;
    localparam int ADDR_LSB = 11;

    localparam logic [DATA_W-1:0] RAMP_STEP = 12'h010;

    // Index 0 is the rightmost entry: ch7 = volume, ch2 = B3.
    localparam logic [NUM_CH-1:0][DATA_W-1:0] CH_RST = {
        12'hFFF, 12'h000, 12'h000, 12'h000,
        12'h000, 12'h800, 12'h000, 12'h000
    };

endpackage

// File: rtl/adc128s_spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulses taken
// against one further delayed copy of the synchronized level.
module spi_sync_edge
    import adc128s_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              dly_q, dly_d;

    always_comb begin
        sync_d = STAGES'({sync_q, d});
        dly_d  = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign lvl  = sync_q[STAGES-1];
    assign rise = lvl & ~dly_q;
    assign fall = ~lvl & dly_q;

endmodule

// File: rtl/adc128s.sv
// adc128s: ADC128S022-style SPI slave returning table[addr of previous frame].
// Define ADC128S_RAMP_EN to bump the returned channel by RAMP_STEP per full frame.
module adc128s
    import adc128s_pkg::*;
#(
    parameter int FRAME_BITS  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic MISO
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .d(SS_n),
        .lvl(ss_lvl), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d(SCLK),
        .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [FRAME_BITS-1:0]  rx_q, rx_d;
    logic [FRAME_BITS-1:0]  tx_q, tx_d;
    logic [2:0]             addr_q, addr_d;
    logic [NUM_CH-1:0][DATA_W-1:0] tbl;
    logic                   mosi_s;

    assign mosi_s = mosi_q[SYNC_STAGES-1];

`ifdef ADC128S_RAMP_EN
    logic [NUM_CH-1:0][DATA_W-1:0] tbl_q, tbl_d;
    assign tbl = tbl_q;
`else
    assign tbl = CH_RST;
`endif

    always_comb begin
        mosi_d = SYNC_STAGES'({mosi_q, MOSI});
        cnt_d  = cnt_q;
        rx_d   = rx_q;
        tx_d   = tx_q;
        addr_d = addr_q;
`ifdef ADC128S_RAMP_EN
        tbl_d  = tbl_q;
`endif
        // SS_n rise has priority over any SCLK edge seen in the same clk.
        if (ss_rise) begin
            cnt_d = '0;
            tx_d  = '0;
            if (cnt_q == CNT_FULL) begin
                addr_d = rx_q[ADDR_MSB:ADDR_LSB];
`ifdef ADC128S_RAMP_EN
                tbl_d[addr_q] = tbl_q[addr_q] + RAMP_STEP;
`endif
            end
        end else if (ss_fall) begin
            cnt_d = '0;
            rx_d  = '0;
            tx_d  = FRAME_BITS'(tbl[addr_q]);
        end else if (ss_lvl) begin
            cnt_d = '0;
            tx_d  = '0;
        end else begin
            if (sclk_rise && cnt_q != CNT_FULL) begin
                rx_d  = {rx_q[FRAME_BITS-2:0], mosi_s};
                cnt_d = cnt_q + 1'b1;
            end
            if (sclk_fall) begin
                tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_q <= '0;
            cnt_q  <= '0;
            rx_q   <= '0;
            tx_q   <= '0;
            addr_q <= '0;
`ifdef ADC128S_RAMP_EN
            tbl_q  <= CH_RST;
`endif
        end else begin
            mosi_q <= mosi_d;
            cnt_q  <= cnt_d;
            rx_q   <= rx_d;
            tx_q   <= tx_d;
            addr_q <= addr_d;
`ifdef ADC128S_RAMP_EN
            tbl_q  <= tbl_d;
`endif
        end
    end

    assign MISO = tx_q[FRAME_BITS-1] & ~ss_lvl;

    logic unused_sclk_lvl;
    assign unused_sclk_lvl = sclk_lvl;

endmodule

// File: tb/tb_adc128s.sv
// tb_adc128s: SPI master at clk/32 with a scoreboard of expected words.
// Compile with the same ADC128S_RAMP_EN setting as the RTL.
module tb_adc128s;

    localparam int HALF = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss_n = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic miso;

    int errors = 0;
    int checks = 0;

    logic [11:0] mtbl [8];
    logic [2:0]  maddr;
    logic [15:0] exp_q [$];

    adc128s #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SS_n(ss_n),
        .SCLK(sclk), .MOSI(mosi), .MISO(miso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mtbl[0] = 12'h000; mtbl[1] = 12'h000;
        mtbl[2] = 12'h800; mtbl[3] = 12'h000;
        mtbl[4] = 12'h000; mtbl[5] = 12'h000;
        mtbl[6] = 12'h000; mtbl[7] = 12'hFFF;
        maddr = 3'd0;
        exp_q.delete();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // rst_at >= 0 pulses rst just before that SCLK rise and abandons the frame.
    task automatic frame(input logic [15:0] word, input int nbits,
                         input int rst_at);
        logic [15:0] rx;
        logic [15:0] exp;
        bit full;
        rx = '0;
        full = (nbits == 16) && (rst_at < 0);
        if (full) exp_q.push_back({4'b0000, mtbl[maddr]});
        @(negedge clk);
        ss_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = word[15-i];
            wait_clk(HALF);
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk("miso_after_rst", {15'd0, miso}, 16'h0000);
                model_reset();
                break;
            end
            rx = {rx[14:0], miso};
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
        wait_clk(HALF);
        ss_n = 1'b1;
        wait_clk(2 * HALF);
        chk("miso_idle", {15'd0, miso}, 16'h0000);
        if (full) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 16'd1, 16'd0);
            end else begin
                exp = exp_q.pop_front();
                chk("frame", rx, exp);
                chk("top4", {12'd0, rx[15:12]}, 16'h0000);
            end
`ifdef ADC128S_RAMP_EN
            mtbl[maddr] = mtbl[maddr] + 12'h010;
`endif
            maddr = word[13:11];
        end
    endtask

    function automatic logic [15:0] aw(input logic [2:0] a);
        return {2'b00, a, 11'd0};
    endfunction

    initial begin
        logic [15:0] w;
        model_reset();
        wait_clk(4);
        rst = 1'b0;
        @(negedge clk);
        chk("miso_reset", {15'd0, miso}, 16'h0000);

        frame(16'h1000, 16, -1);
        frame(aw(3'd7), 16, -1);
        frame(aw(3'd0), 16, -1);

        frame(aw(3'd3), 9, -1);
        frame(aw(3'd2), 16, -1);

        frame(aw(3'd5), 16, 6);
        frame(aw(3'd2), 16, -1);

        frame(aw(3'd2), 16, -1);
        frame(aw(3'd2), 16, -1);
        frame(aw(3'd7), 16, -1);
        frame(aw(3'd7), 16, -1);
        frame(aw(3'd1), 16, -1);

        for (int k = 0; k < 100; k++) begin
            w = 16'($urandom);
            frame(w, 16, -1);
        end

        if (exp_q.size() != 0) chk("sb_left", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
